// File: rtl/mult_shift_add_datapath.sv
// Shift-add multiplier datapath: operand registers, add/shift product register,
// shift counter with overrun flag, and a valid/ready result output stage that
// captures the product on the rising edge of the controller's done level.
module mult_shift_add_datapath #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic               c_write,
  input  logic               c_shift,
  input  logic               done,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic [WIDTH-1:0]   multiplier_in,
  input  logic               result_ready,
  output logic               last_bit,
  output logic [2*WIDTH-1:0] product,
  output logic               result_valid,
  output logic [CNT_W-1:0]   shift_count,
  output logic               overrun
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  logic [WIDTH-1:0] m_q, m_d;
  logic             c_q, c_d;
  logic [PW-1:0]    p_q, p_d;
  logic             done_q;
  logic [PW-1:0]    product_q, product_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH:0]   sum;
  logic             shift_acc;

  // Operand load, add / shift / add-and-shift, shift counting and overrun
  always_comb begin
    m_d       = m_q;
    c_d       = c_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    shift_acc = 1'b0;
    sum       = {1'b0, p_q[PW-1:WIDTH]} + {1'b0, m_q};

    if (start) begin
      m_d   = multiplicand_in;
      p_d   = {{WIDTH{1'b0}}, multiplier_in};
      c_d   = 1'b0;
      cnt_d = '0;
      ovr_d = 1'b0;
    end else if (!done) begin
      unique case ({c_write, c_shift})
        2'b10: {c_d, p_d[PW-1:WIDTH]} = sum;
        2'b01: begin
          {c_d, p_d} = {1'b0, c_q, p_q[PW-1:1]};
          shift_acc  = 1'b1;
        end
        // Add and shift in one cycle: the fresh sum (with its carry) lands
        // directly in the upper bits of the shifted register.
        2'b11: begin
          {c_d, p_d} = {1'b0, sum, p_q[WIDTH-1:1]};
          shift_acc  = 1'b1;
        end
        default: ;
      endcase

      if (shift_acc) begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q >= WIDTH_C) ovr_d = 1'b1;
      end
    end
  end

  // Result capture on done rising edge; capture takes priority over acceptance
  always_comb begin
    product_d = product_q;
    valid_d   = valid_q;
    if (done && !done_q) begin
      product_d = p_q;
      valid_d   = 1'b1;
    end else if (valid_q && result_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_q       <= '0;
      c_q       <= 1'b0;
      p_q       <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      m_q       <= m_d;
      c_q       <= c_d;
      p_q       <= p_d;
      done_q    <= done;
      product_q <= product_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  assign last_bit     = p_q[0];
  assign product      = product_q;
  assign result_valid = valid_q;
  assign shift_count  = cnt_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_mult_shift_add_datapath.sv
// Bench for the shift-add multiplier datapath at WIDTH=8, CNT_W=4. Expected
// products are queued when done is raised; a monitor pops and compares each
// time a result is accepted on the output handshake.
module tb_mult_shift_add_datapath;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          CLK;
  logic          RST_N;
  logic          start, c_write, c_shift, done, result_ready;
  logic [W-1:0]  multiplicand_in, multiplier_in;
  logic          last_bit, result_valid, overrun;
  logic [2*W-1:0] product;
  logic [CW-1:0] shift_count;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [2*W-1:0] exp_q[$];

  mult_shift_add_datapath #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .c_write(c_write),
    .c_shift(c_shift), .done(done), .multiplicand_in(multiplicand_in),
    .multiplier_in(multiplier_in), .result_ready(result_ready),
    .last_bit(last_bit), .product(product), .result_valid(result_valid),
    .shift_count(shift_count), .overrun(overrun)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expected product
  always @(negedge CLK) begin
    if (RST_N && result_valid && result_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected actual=%0h required=none", product);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if (product !== e) begin
          bad++;
          $display("FAIL sb_product actual=%0h required=%0h", product, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_ctl();
    start = 1'b0; c_write = 1'b0; c_shift = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; multiplicand_in = a; multiplier_in = b;
    tick();
    start = 1'b0;
  endtask

  // FSM-equivalent bit loop; 'sep' uses a write cycle then a shift cycle per 1 bit
  task automatic run_bits(input logic [W-1:0] b, input int unsigned nbits, input bit sep);
    for (int unsigned i = 0; i < nbits; i++) begin
      chk("last_bit", 64'(last_bit), 64'(b[i]));
      if (b[i]) begin
        if (sep) begin
          c_write = 1'b1; tick(); c_write = 1'b0;
          c_shift = 1'b1; tick(); c_shift = 1'b0;
        end else begin
          c_write = 1'b1; c_shift = 1'b1; tick(); clr_ctl();
        end
      end else begin
        c_shift = 1'b1; tick(); c_shift = 1'b0;
      end
    end
  endtask

  task automatic raise_done(input logic [2*W-1:0] exp, input bit rdy);
    exp_q.push_back(exp);
    done = 1'b1; result_ready = rdy;
    tick();
    chk("valid_after_done", 64'(result_valid), 64'd1);
    done = 1'b0; result_ready = 1'b0;
    tick();
  endtask

  task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit sep,
                     input logic [2*W-1:0] exp, input bit rdy_at_done);
    load(a, b);
    chk("cnt_after_load", 64'(shift_count), 64'd0);
    run_bits(b, W, sep);
    chk("cnt_after_mul", 64'(shift_count), 64'd8);
    chk("ovr_after_mul", 64'(overrun), 64'd0);
    raise_done(exp, rdy_at_done);
  endtask

  task automatic accept();
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    chk("valid_after_accept", 64'(result_valid), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_last_bit"}, 64'(last_bit), 64'd0);
    chk({tag, "_product"},  64'(product), 64'd0);
    chk({tag, "_valid"},    64'(result_valid), 64'd0);
    chk({tag, "_cnt"},      64'(shift_count), 64'd0);
    chk({tag, "_ovr"},      64'(overrun), 64'd0);
  endtask

  initial begin
    RST_N = 1'b0; clr_ctl(); done = 1'b0; result_ready = 1'b0;
    multiplicand_in = '0; multiplier_in = '0;
    #1;
    chk_zero("reset");
    #11;
    RST_N = 1'b1;

    // Basic multiply, combined add+shift cycles
    mul(8'd13, 8'd11, 1'b0, 16'h008F, 1'b0);
    accept();

    // Carry path with separate write and shift cycles
    mul(8'd255, 8'd255, 1'b1, 16'hFE01, 1'b0);
    accept();

    // Zero and identity
    mul(8'd200, 8'd0, 1'b0, 16'h0000, 1'b0);
    accept();
    mul(8'd1, 8'd200, 1'b0, 16'h00C8, 1'b0);
    accept();

    // Handshake: hold, accept, then overwrite coincident with acceptance
    mul(8'd13, 8'd11, 1'b0, 16'h008F, 1'b0);
    for (int unsigned k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", 64'(result_valid), 64'd1);
      chk("hold_product", 64'(product), 64'h008F);
    end
    accept();
    mul(8'd3, 8'd5, 1'b0, 16'h000F, 1'b0);
    mul(8'd7, 8'd9, 1'b0, 16'h003F, 1'b1);
    chk("overwrite_product", 64'(product), 64'h003F);
    chk("overwrite_valid", 64'(result_valid), 64'd1);
    accept();

    // Overrun, counter saturation, cleared by start
    load(8'd0, 8'd0);
    for (int unsigned k = 0; k < 8; k++) begin
      c_shift = 1'b1; tick(); c_shift = 1'b0;
    end
    chk("ovr_at_8", 64'(overrun), 64'd0);
    c_shift = 1'b1; tick(); c_shift = 1'b0;
    chk("ovr_at_9", 64'(overrun), 64'd1);
    chk("cnt_at_9", 64'(shift_count), 64'd9);
    for (int unsigned k = 0; k < 8; k++) begin
      c_shift = 1'b1; tick(); c_shift = 1'b0;
    end
    chk("cnt_saturated", 64'(shift_count), 64'd15);
    chk("ovr_sticky", 64'(overrun), 64'd1);
    load(8'd0, 8'd0);
    chk("ovr_cleared", 64'(overrun), 64'd0);
    chk("cnt_cleared", 64'(shift_count), 64'd0);

    // Shift ignored while done is high
    load(8'd5, 8'd6);
    c_shift = 1'b1; tick(); c_shift = 1'b0;
    chk("pre_done_lb", 64'(last_bit), 64'd1);
    exp_q.push_back(16'h0003);
    done = 1'b1; c_shift = 1'b1;
    for (int unsigned k = 0; k < 2; k++) begin
      tick();
      chk("done_shift_cnt", 64'(shift_count), 64'd1);
      chk("done_shift_lb", 64'(last_bit), 64'd1);
    end
    done = 1'b0; c_shift = 1'b0;
    tick();
    accept();

    // start concurrent with c_write loads only
    start = 1'b1; c_write = 1'b1; multiplicand_in = 8'd9; multiplier_in = 8'd2;
    tick(); clr_ctl();
    chk("start_wr_lb", 64'(last_bit), 64'd0);
    c_shift = 1'b1; tick(); c_shift = 1'b0;
    c_write = 1'b1; tick(); c_write = 1'b0;
    raise_done(16'h0901, 1'b0);
    accept();

    // Asynchronous reset mid-multiply with a pending result
    mul(8'd3, 8'd5, 1'b0, 16'h000F, 1'b0);
    load(8'd13, 8'd11);
    run_bits(8'd11, 4, 1'b0);
    #3;
    RST_N = 1'b0;
    exp_q.delete();
    #1;
    chk_zero("async_reset");
    #2;
    RST_N = 1'b1;
    mul(8'd13, 8'd11, 1'b0, 16'h008F, 1'b0);
    accept();

    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
